// File: rtl/csr_irq_vec.sv
// Machine-mode CSR file with NUM_IRQ prioritised external interrupts and vectored mtvec.
// Optional 64-bit mcycle/minstret counters are enabled by defining CSR_COUNTERS_EN.
module csr_irq_vec #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [11:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic               write_i,
  input  logic               set_i,
  input  logic               clear_i,
  input  logic               interrupt_i,
  input  logic               mret_i,
  input  logic [31:0]        pc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               instret_i,
  output logic [31:0]        rdata_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        trap_pc_o,
  output logic               ipending_o,
  output logic [3:0]         irq_id_o
);

  localparam logic [31:0] MIE_MASK    = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MCAUSE_MASK = 32'h8000_001F;

  // Vectoring modes 2/3 are reserved; they collapse to direct mode.
  function automatic logic [31:0] coerce_mtvec(input logic [31:0] v);
    return {v[31:2], v[1] ? 2'b00 : v[1:0]};
  endfunction

  logic               st_mie, st_mpie;
  logic [31:0]        mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [NUM_IRQ-1:0] irq_q, pend;
  logic [31:0]        mstatus_rd, mip_rd, wval;
  logic               take_irq, do_mret, csr_op;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign mip_rd     = 32'(irq_q) << 16;
  assign pend       = irq_q & mie_q[16 +: NUM_IRQ];
  assign ipending_o = st_mie & (|pend);
  assign mepc_o     = mepc_q;

  always_comb begin
    irq_id_o = 4'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (pend[k]) irq_id_o = 4'(k);
  end

  always_comb begin
    rdata_o = 32'h0;
    case (addr_i)
      12'h300: rdata_o = mstatus_rd;
      12'h304: rdata_o = mie_q;
      12'h305: rdata_o = mtvec_q;
      12'h340: rdata_o = mscratch_q;
      12'h341: rdata_o = mepc_q;
      12'h342: rdata_o = mcause_q;
      12'h344: rdata_o = mip_rd;
`ifdef CSR_COUNTERS_EN
      12'hB00: rdata_o = mcycle_q[31:0];
      12'hB80: rdata_o = mcycle_q[63:32];
      12'hB02: rdata_o = minstret_q[31:0];
      12'hB82: rdata_o = minstret_q[63:32];
`endif
      default: rdata_o = 32'h0;
    endcase
  end

  always_comb begin
    trap_pc_o = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && mcause_q[31])
      trap_pc_o = {mtvec_q[31:2], 2'b00} + {25'b0, mcause_q[4:0], 2'b00};
  end

  // Strobe arbitration: interrupt > mret > write > set > clear.
  assign take_irq = interrupt_i & ipending_o;
  assign do_mret  = ~interrupt_i & mret_i;
  assign csr_op   = ~interrupt_i & ~mret_i & (write_i | set_i | clear_i);
  assign wval     = write_i ? wdata_i :
                    set_i   ? (rdata_o | wdata_i) : (rdata_o & ~wdata_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= coerce_mtvec(MTVEC_RESET);
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      irq_q      <= '0;
    end else begin
      irq_q <= irq_i;
      if (take_irq) begin
        mepc_q   <= {pc_i[31:2], 2'b00};
        mcause_q <= 32'h8000_0010 + {28'b0, irq_id_o};
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (do_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (csr_op) begin
        case (addr_i)
          12'h300: begin st_mie <= wval[3]; st_mpie <= wval[7]; end
          12'h304: mie_q      <= wval & MIE_MASK;
          12'h305: mtvec_q    <= coerce_mtvec(wval);
          12'h340: mscratch_q <= wval;
          12'h341: mepc_q     <= {wval[31:2], 2'b00};
          12'h342: mcause_q   <= wval & MCAUSE_MASK;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // A CSR access to either half pre-empts that counter's increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (csr_op && addr_i == 12'hB00)      mcycle_q[31:0]  <= wval;
      else if (csr_op && addr_i == 12'hB80) mcycle_q[63:32] <= wval;
      else                                  mcycle_q        <= mcycle_q + 64'h1;
      if (csr_op && addr_i == 12'hB02)      minstret_q[31:0]  <= wval;
      else if (csr_op && addr_i == 12'hB82) minstret_q[63:32] <= wval;
      else if (instret_i)                   minstret_q        <= minstret_q + 64'h1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_irq_vec.sv
// Scoreboard bench for csr_irq_vec: stimulus queues expected values, a negedge monitor compares.
module tb_csr_irq_vec;
  localparam int          NUM_IRQ = 4;
  localparam logic [31:0] MTV_RST = 32'h0000_0202;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [11:0]       addr_i = '0;
  logic [31:0]       wdata_i = '0, pc_i = '0;
  logic              write_i = 0, set_i = 0, clear_i = 0, interrupt_i = 0, mret_i = 0, instret_i = 0;
  logic [NUM_IRQ-1:0] irq_i = '0;
  logic [31:0]       rdata_o, mepc_o, trap_pc_o;
  logic              ipending_o;
  logic [3:0]        irq_id_o;

  csr_irq_vec #(.NUM_IRQ(NUM_IRQ), .MTVEC_RESET(MTV_RST)) dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .write_i(write_i), .set_i(set_i), .clear_i(clear_i),
    .interrupt_i(interrupt_i), .mret_i(mret_i), .pc_i(pc_i), .irq_i(irq_i),
    .instret_i(instret_i), .rdata_o(rdata_o), .mepc_o(mepc_o),
    .trap_pc_o(trap_pc_o), .ipending_o(ipending_o), .irq_id_o(irq_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 rdata, 1 ipending, 2 irq_id, 3 trap_pc, 4 mepc
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic mon_vld = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  always @(negedge clk) begin
    if (mon_vld) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        exp_t it;
        logic [31:0] got;
        it = sb.pop_front();
        case (it.kind)
          0:       got = rdata_o;
          1:       got = 32'(ipending_o);
          2:       got = 32'(irq_id_o);
          3:       got = trap_pc_o;
          default: got = mepc_o;
        endcase
        if (got !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, expected %h", it.name, got, it.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input int kind, input logic [11:0] a, input logic [31:0] e, input string nm);
    addr_i = a;
    sb.push_back('{kind, e, nm});
    mon_vld = 1'b1;
    tick();
    mon_vld = 1'b0;
  endtask

  // op: 0 write, 1 set, 2 clear
  task automatic csr(input int op, input logic [11:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d;
    write_i = (op == 0); set_i = (op == 1); clear_i = (op == 2);
    tick();
    write_i = 0; set_i = 0; clear_i = 0;
  endtask

  task automatic trap(input logic [31:0] pc);
    interrupt_i = 1; pc_i = pc;
    tick();
    interrupt_i = 0;
  endtask

  task automatic mret();
    mret_i = 1;
    tick();
    mret_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Strobes held during reset must be overridden.
    write_i = 1; addr_i = 12'h340; wdata_i = 32'hDEAD_BEEF; interrupt_i = 1; irq_i = 4'hF;
    tick(); tick();
    rst_i = 0; write_i = 0; interrupt_i = 0; irq_i = '0;
    chk(0, 12'h300, 32'h0000_1800, "reset_mstatus");
    chk(0, 12'h305, 32'h0000_0200, "reset_mtvec");
    chk(0, 12'h344, 32'h0, "reset_mip");
    chk(0, 12'h340, 32'h0, "reset_mscratch");
    chk(1, 12'h0, 32'h0, "reset_ipending");
    chk(2, 12'h0, 32'h0, "reset_irq_id");
    chk(4, 12'h0, 32'h0, "reset_mepc");

    // mie masking and interrupt ignored while MIE=0
    csr(0, 12'h304, 32'hFFFF_FFFF);
    chk(0, 12'h304, 32'h000F_0000, "mie_mask");
    irq_i = 4'b1010;
    tick();
    chk(2, 12'h0, 32'd1, "irq_id_masked");
    chk(1, 12'h0, 32'h0, "ipending_mie0");
    trap(32'h0000_0055);
    chk(4, 12'h0, 32'h0, "ignored_trap_mepc");
    chk(0, 12'h342, 32'h0, "ignored_trap_mcause");
    chk(0, 12'h300, 32'h0000_1800, "ignored_trap_mstatus");
    csr(0, 12'h344, 32'hFFFF_FFFF);
    chk(0, 12'h344, 32'h000A_0000, "mip_readonly");

    // priority and trap entry
    csr(1, 12'h300, 32'h8);
    chk(0, 12'h300, 32'h0000_1808, "mstatus_set_mie");
    chk(1, 12'h0, 32'h1, "ipending");
    chk(2, 12'h0, 32'd1, "irq_id_prio");
    trap(32'h0000_0123);
    chk(4, 12'h0, 32'h0000_0120, "trap_mepc");
    chk(0, 12'h342, 32'h8000_0011, "trap_mcause");
    chk(0, 12'h300, 32'h0000_1880, "trap_mstatus");
    chk(3, 12'h0, 32'h0000_0200, "trap_pc_direct");
    chk(1, 12'h0, 32'h0, "ipending_after_trap");
    mret();
    chk(0, 12'h300, 32'h0000_1888, "mret_mstatus");

    // vectored mode
    csr(0, 12'h305, 32'h0000_1001);
    irq_i = 4'b0100;
    tick();
    chk(2, 12'h0, 32'd2, "irq_id_line2");
    trap(32'h0000_0400);
    chk(3, 12'h0, 32'h0000_1048, "trap_pc_vectored");
    chk(0, 12'h305, 32'h0000_1001, "mtvec_vectored");
    chk(0, 12'h342, 32'h8000_0012, "mcause_line2");
    chk(4, 12'h0, 32'h0000_0400, "mepc_line2");
    mret();
    csr(0, 12'h305, 32'h0000_1003);
    chk(0, 12'h305, 32'h0000_1000, "mtvec_mode3_coerce");
    trap(32'h0000_0500);
    chk(3, 12'h0, 32'h0000_1000, "trap_pc_mode3");

    // mscratch ops, write beats clear
    addr_i = 12'h340; wdata_i = 32'hA5A5_0F0F; write_i = 1; clear_i = 1;
    tick();
    write_i = 0; clear_i = 0;
    chk(0, 12'h340, 32'hA5A5_0F0F, "write_beats_clear");
    csr(1, 12'h340, 32'h0000_F0F0);
    chk(0, 12'h340, 32'hA5A5_FFFF, "mscratch_set");
    csr(2, 12'h340, 32'hFF00_0000);
    chk(0, 12'h340, 32'h00A5_FFFF, "mscratch_clear");

    // write masks
    csr(0, 12'h341, 32'hFFFF_FFFF);
    chk(0, 12'h341, 32'hFFFF_FFFC, "mepc_mask");
    csr(0, 12'h342, 32'hFFFF_FFFF);
    chk(0, 12'h342, 32'h8000_001F, "mcause_mask");
    csr(0, 12'h300, 32'hFFFF_FFFF);
    chk(0, 12'h300, 32'h0000_1888, "mstatus_mask");
    csr(0, 12'h7C0, 32'h1234_5678);
    chk(0, 12'h7C0, 32'h0, "unmapped_addr");

    // interrupt beats write, mret beats write
    addr_i = 12'h340; wdata_i = 32'h0; write_i = 1; interrupt_i = 1; pc_i = 32'h0000_0800;
    tick();
    write_i = 0; interrupt_i = 0;
    chk(0, 12'h340, 32'h00A5_FFFF, "irq_beats_write");
    chk(4, 12'h0, 32'h0000_0800, "irq_beats_write_mepc");
    chk(0, 12'h300, 32'h0000_1880, "irq_beats_write_mstatus");
    addr_i = 12'h300; wdata_i = 32'h0; write_i = 1; mret_i = 1;
    tick();
    write_i = 0; mret_i = 0;
    chk(0, 12'h300, 32'h0000_1888, "mret_beats_write");
    irq_i = '0;
    tick();
    chk(1, 12'h0, 32'h0, "ipending_released");
    chk(2, 12'h0, 32'h0, "irq_id_released");

`ifdef CSR_COUNTERS_EN
    rst_i = 1;
    tick();
    rst_i = 0;
    for (int i = 0; i < 10; i++) begin
      instret_i = (i == 2 || i == 5 || i == 7);
      tick();
    end
    instret_i = 0;
    chk(0, 12'hB00, 32'd10, "mcycle_10");
    chk(0, 12'hB02, 32'd3, "minstret_3");
    csr(0, 12'hB00, 32'hFFFF_FFFF);
    tick();
    chk(0, 12'hB80, 32'd1, "mcycle_carry");
    chk(0, 12'hB82, 32'd0, "minstret_hi");
`else
    chk(0, 12'hB00, 32'h0, "mcycle_absent");
    csr(0, 12'hB80, 32'hFFFF_FFFF);
    chk(0, 12'hB80, 32'h0, "mcycleh_absent");
`endif

    tick();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_irq_vec.md
Name: csr_irq_vec

Overview:
- Machine-mode CSR file for the multicycle RISC-V core. Parametrised successor of the single-interrupt CSR block.
- Supports NUM_IRQ prioritised external interrupt lines (mip/mie bits 16+k), mscratch, vectored mtvec, and a computed trap target.
- Sits beside the control FSM. The FSM issues write/set/clear/interrupt/mret strobes and takes trap_pc_o / mepc_o for PC redirection.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines; legal range 1..16; line k maps to mip/mie bit 16+k.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits[1:0] are coerced as on a write.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- addr_i  in  12  CSR address
- wdata_i  in  32  write/set/clear operand
- write_i  in  1  CSR write strobe
- set_i  in  1  CSR set-bits strobe
- clear_i  in  1  CSR clear-bits strobe
- interrupt_i  in  1  take interrupt trap this cycle
- mret_i  in  1  return from trap this cycle
- pc_i  in  32  PC to save into mepc on trap
- irq_i  in  NUM_IRQ  external interrupt request levels
- instret_i  in  1  instruction-retired pulse (used only with CSR_COUNTERS_EN)
- rdata_o  out  32  combinational read data for addr_i
- mepc_o  out  32  mepc
- trap_pc_o  out  32  trap handler address
- ipending_o  out  1  an enabled interrupt is pending and globally enabled
- irq_id_o  out  4  index of highest-priority pending enabled line

Behaviour:
- Single clock domain, clk_i. Reset rst_i is synchronous and active-high. On reset:
  - mstatus = 32'h0000_1800
  - mie, mscratch, mepc, mcause, irq sync register = 0
  - mtvec = MTVEC_RESET
  - Therefore ipending_o = 0, irq_id_o = 0, mepc_o = 0.
- Register map:
  - 0x300 mstatus: MIE bit 3, MPIE bit 7, MPP[12:11] read-only 2'b11; all other bits read 0.
  - 0x304 mie: only bits [16+NUM_IRQ-1:16] writable.
  - 0x305 mtvec: a mode field in [1:0] of 2 or 3 is stored as 0.
  - 0x340 mscratch: full 32 bits.
  - 0x341 mepc: bits[1:0] forced 0.
  - 0x342 mcause: bit 31 and bits[4:0] writable.
  - 0x344 mip: read-only; writes ignored.
  - Any other address reads 0; writes to it are ignored.
- Read path: rdata_o is combinational from addr_i and current register state, with zero latency.
- Interrupt sampling:
  - irq_i is registered once into mip[16+k].
  - An assertion is visible in mip one cycle later. Level-sensitive, no latching.
- Pending logic (combinational from registered state):
  - pend = mip & mie.
  - ipending_o = mstatus.MIE & |pend.
  - irq_id_o = lowest index k with pend[16+k] set (lowest index = highest priority); 0 when none.
- Command priority when several strobes are high: interrupt_i > mret_i > write_i > set_i > clear_i. Only the winner takes effect.
- interrupt_i:
  - Effective only if ipending_o = 1; otherwise ignored with no state change.
  - Effect: mepc <= {pc_i[31:2], 2'b00}; mcause <= 32'h8000_0000 | (16 + irq_id_o); MPIE <= MIE; MIE <= 0.
- mret_i: MIE <= MPIE; MPIE <= 1.
- set_i: reg <= reg | wdata_i. clear_i: reg <= reg & ~wdata_i. The same per-register write masks apply.
- trap_pc_o (combinational):
  - mtvec mode 0: {mtvec[31:2], 2'b00}.
  - mtvec mode 1 (vectored) and mcause[31] = 1: {mtvec[31:2], 2'b00} + 4*mcause[4:0], 32-bit wrap.
  - The FSM samples trap_pc_o the cycle after interrupt_i.
- Reset asserted mid-operation overrides every strobe in that cycle.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- With the macro defined:
  - 64-bit mcycle (0xB00 low / 0xB80 high) increments every cycle.
  - 64-bit minstret (0xB02 / 0xB82) increments when instret_i = 1.
  - Both reset to 0 and wrap at 2^64.
  - A write/set/clear to either half loads that half; the counter does not increment that cycle.
- Without the macro: those addresses read 0, writes are ignored, and instret_i is unused.

Test Plan:
- Reset check: assert rst_i, then read 0x300/0x305/0x344 -> returns 32'h1800 / MTVEC_RESET / 0; ipending_o = 0.
- Interrupt priority:
  - Stimulus: mie = 32'h000F_0000, set mstatus bit 3, drive irq_i = 4'b1010.
  - Next cycle: ipending_o = 1, irq_id_o = 1.
  - Then interrupt_i with pc_i = 32'h0000_0123: mepc = 32'h120, mcause = 32'h8000_0011, mstatus = 32'h1880.
- Vectored trap:
  - Stimulus: write mtvec = 32'h0000_1001, then take a trap on line 2.
  - Response: trap_pc_o = 32'h1000 + 4*18 = 32'h1048. Same sequence with mtvec = 32'h1003 -> mtvec reads 32'h1000 and trap_pc_o = 32'h1000.
- mret: from mstatus = 32'h1880, pulse mret_i -> mstatus = 32'h1888.
- Masking and ignore cases:
  - interrupt_i with MIE = 0 and irq_i active -> no change to mepc or mcause.
  - Write 0xFFFF_FFFF to 0x344 -> mip unchanged.
  - write_i and clear_i together on mscratch -> write wins.
- CSR_COUNTERS_EN: release reset, run 10 cycles with instret_i high on 3 of them.
  - Reading 0xB00 / 0xB02 returns 10 / 3 (minus offset by read cycle).
  - Write 0xFFFF_FFFF to 0xB00; two cycles later 0xB80 reads 1.
